// File: rtl/riscv_mem_pkg.sv
// Shared memory-subsystem constants and the store-buffer entry type.
// Consumed by store_buffer and store_buffer_match.
package riscv_mem_pkg;

   localparam int SB_DEPTH    = 4;
   localparam int WORD_OFFSET = 2;
   localparam int XLEN        = 32;

   typedef struct packed {
      logic [XLEN-1:0] addr;
      logic [XLEN-1:0] data;
   } sb_entry_t;

endpackage

// File: rtl/store_buffer_match.sv
// Word-granular load-address comparator across the valid store-buffer entries.
// With STORE_BUFFER_FWD_EN defined it also selects the youngest matching entry.
module store_buffer_match
   import riscv_mem_pkg::*;
#(
   parameter int DEPTH = SB_DEPTH,
   parameter int AW    = 32,
   parameter int PW    = $clog2(DEPTH)
) (
   input  logic [AW-1:0] entryAddr_i [DEPTH],
   input  logic [PW-1:0] rdPtr_i,
   input  logic [PW:0]   count_i,
   input  logic [AW-1:0] loadAddr_i,
`ifdef STORE_BUFFER_FWD_EN
   output logic [PW-1:0] hitIdx_o,
`endif
   output logic          hit_o
);

   logic [DEPTH-1:0] matchVec;

   // Walk entries by age from the head so only occupied slots can match.
   always_comb begin
      logic [PW-1:0] idx;
      idx      = '0;
      matchVec = '0;
      for (int k = 0; k < DEPTH; k++) begin
         idx = rdPtr_i + PW'(k);
         if ((PW+1)'(k) < count_i)
            matchVec[idx] = (entryAddr_i[idx][AW-1:WORD_OFFSET] == loadAddr_i[AW-1:WORD_OFFSET]);
      end
   end

   assign hit_o = |matchVec;

`ifdef STORE_BUFFER_FWD_EN
   // Later ages overwrite earlier ones, leaving the youngest match.
   always_comb begin
      logic [PW-1:0] idx;
      idx      = '0;
      hitIdx_o = '0;
      for (int k = 0; k < DEPTH; k++) begin
         idx = rdPtr_i + PW'(k);
         if (matchVec[idx])
            hitIdx_o = idx;
      end
   end
`endif

endmodule

// File: rtl/store_buffer.sv
// FIFO store buffer between CPU and memory write port, with load-hazard handling.
// Define STORE_BUFFER_FWD_EN to forward pending store data instead of stalling loads.
module store_buffer
   import riscv_mem_pkg::*;
#(
   parameter int DEPTH = SB_DEPTH,
   parameter int AW    = 32,
   parameter int DW    = 32
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          MemWrite,
   input  logic          MemRead,
   input  logic [AW-1:0] Mem_WrAddr,
   input  logic [DW-1:0] Mem_WrData,
   output logic [DW-1:0] ReadData,
   output logic          Stall,
   output logic          bus_wr_valid,
   input  logic          bus_wr_ready,
   output logic [AW-1:0] bus_wr_addr,
   output logic [DW-1:0] bus_wr_data,
   output logic [AW-1:0] bus_rd_addr,
   input  logic [DW-1:0] bus_rd_data
);

   localparam int PW = $clog2(DEPTH);

   logic [AW-1:0] addr_q [DEPTH];
   logic [DW-1:0] data_q [DEPTH];
   logic [PW-1:0] wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
   logic [PW:0]   count_q, count_d;
   logic          full, hit, push, pop;
`ifdef STORE_BUFFER_FWD_EN
   logic [PW-1:0] hitIdx;
`endif

   store_buffer_match #(.DEPTH(DEPTH), .AW(AW), .PW(PW)) u_match (
      .entryAddr_i (addr_q),
      .rdPtr_i     (rdPtr_q),
      .count_i     (count_q),
      .loadAddr_i  (Mem_WrAddr),
`ifdef STORE_BUFFER_FWD_EN
      .hitIdx_o    (hitIdx),
`endif
      .hit_o       (hit)
   );

   assign full         = (count_q == (PW+1)'(DEPTH));
   assign bus_wr_valid = !reset && (count_q != '0);
   assign bus_wr_addr  = addr_q[rdPtr_q];
   assign bus_wr_data  = data_q[rdPtr_q];
   assign bus_rd_addr  = Mem_WrAddr;

   // Reset masks stall and forwarding so the CPU sees plain memory while clearing.
   always_comb begin
      Stall    = 1'b0;
      ReadData = bus_rd_data;
      if (!reset) begin
         if (MemWrite && full)
            Stall = 1'b1;
`ifdef STORE_BUFFER_FWD_EN
         if (MemRead && hit)
            ReadData = data_q[hitIdx];
`else
         if (MemRead && hit)
            Stall = 1'b1;
`endif
      end
   end

   assign push = MemWrite && !Stall && !reset;
   assign pop  = bus_wr_valid && bus_wr_ready;

   always_comb begin
      wrPtr_d = wrPtr_q + PW'(push);
      rdPtr_d = rdPtr_q + PW'(pop);
      count_d = count_q + (PW+1)'(push) - (PW+1)'(pop);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
      end else begin
         wrPtr_q <= wrPtr_d;
         rdPtr_q <= rdPtr_d;
         count_q <= count_d;
      end
   end

   // Entry storage needs no reset; occupancy is tracked by the pointers.
   always_ff @(posedge clk) begin
      if (push) begin
         addr_q[wrPtr_q] <= Mem_WrAddr;
         data_q[wrPtr_q] <= Mem_WrData;
      end
   end

endmodule
